sad_search_ctrl: RTL and testbench



---
 rtl/sad_pkg.sv | 13 +
 rtl/raster_counter.sv | 35 +++
 rtl/sad_search_ctrl.sv | 133 +++++++++++++
 tb/tb_sad_search_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared constants and state encoding for the SAD search controller
package sad_pkg;
   localparam int WIN     = 4;
   localparam int COORD_W = 8;
   localparam int SAD_W   = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [SAD_W-1:0] SAD_MAX = '1;
endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - X/Y raster position counter with wrap limits and a last-position flag
module raster_counter
   import sad_pkg::*;
#(
   parameter int W = COORD_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         advance,
   input  logic [W-1:0] x_lim,
   input  logic [W-1:0] y_lim,
   output logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic         last
);

   assign last = (x == x_lim) && (y == y_lim);

   // Step along the row; wrapping past the last column moves to the next row
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x == x_lim) begin
            x <= '0;
            y <= y + W'(1);
         end else begin
            x <= x + W'(1);
         end
      end
   end

endmodule

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - full-search block-matching scan sequencer with best-SAD tracking
module sad_search_ctrl
   import sad_pkg::*;
#(
   parameter int MAX_OUT = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Abort,
   input  logic [COORD_W-1:0] FrameW,
   input  logic [COORD_W-1:0] FrameH,
   output logic               WinValid,
   input  logic               WinReady,
   output logic [COORD_W-1:0] WinX,
   output logic [COORD_W-1:0] WinY,
   input  logic               SadValid,
   input  logic [SAD_W-1:0]   SadIn,
   output logic               Busy,
   output logic               Done,
   output logic [SAD_W-1:0]   BestSad,
   output logic [COORD_W-1:0] BestX,
   output logic [COORD_W-1:0] BestY,
   output logic               Error
);

   localparam int OW  = $clog2(MAX_OUT) + 1;
   localparam int OWP = OW + 1;
   localparam logic [COORD_W-1:0] WIN_C = COORD_W'(WIN);

   logic [1:0]         state;
   logic [COORD_W-1:0] frame_w, frame_h, x_lim, y_lim;
   logic [OW-1:0]      outstanding;
   // results still owed by the pipeline for positions issued before an Abort
   logic [OWP-1:0]     orphans, orphan_next;
   logic [COORD_W-1:0] res_x, res_y;
   logic               issue_last, res_last;
   logic               start_ok, too_small, issue_fire, real_ret, orphan_ret, stray;

   assign x_lim      = frame_w - WIN_C;
   assign y_lim      = frame_h - WIN_C;
   assign too_small  = (FrameW < WIN_C) || (FrameH < WIN_C);
   assign start_ok   = (state == ST_IDLE) && Start && !Abort;
   assign WinValid   = (state == ST_ISSUE) && (outstanding < OW'(MAX_OUT));
   assign issue_fire = WinValid && WinReady;
   assign orphan_ret = SadValid && (orphans != '0);
   assign real_ret   = SadValid && (orphans == '0) && (outstanding != '0);
   assign stray      = SadValid && (orphans == '0) && (outstanding == '0);
   assign Busy       = (state == ST_ISSUE) || (state == ST_DRAIN);
   assign Done       = (state == ST_DONE);

   raster_counter #(.W(COORD_W)) u_issue (
      .clk(Clk), .reset(Reset), .clear(start_ok), .advance(issue_fire),
      .x_lim(x_lim), .y_lim(y_lim), .x(WinX), .y(WinY), .last(issue_last)
   );

   raster_counter #(.W(COORD_W)) u_result (
      .clk(Clk), .reset(Reset), .clear(start_ok), .advance(real_ret),
      .x_lim(x_lim), .y_lim(y_lim), .x(res_x), .y(res_y), .last(res_last)
   );

   // Abort hands everything in flight (including this cycle's traffic) to the orphan count
   always_comb begin
      orphan_next = orphans;
      if (Abort)
         orphan_next = orphans + OWP'(outstanding) + OWP'(issue_fire)
                       - OWP'(real_ret) - OWP'(orphan_ret);
      else if (orphan_ret)
         orphan_next = orphans - OWP'(1);
   end

   // Scan sequencing: issue all positions, wait for results, pulse Done once
   always_ff @(posedge Clk) begin
      if (Reset || Abort) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (Start) state <= too_small ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (issue_fire && issue_last) state <= ST_DRAIN;
            ST_DRAIN: if ((real_ret && res_last) || (outstanding == '0)) state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Positions in flight; a simultaneous issue and return cancel out
   always_ff @(posedge Clk) begin
      if (Reset || Abort || start_ok)
         outstanding <= '0;
      else if (issue_fire && !real_ret)
         outstanding <= outstanding + OW'(1);
      else if (!issue_fire && real_ret)
         outstanding <= outstanding - OW'(1);
   end

   // Orphaned results are swallowed silently ahead of any new search's results
   always_ff @(posedge Clk) begin
      if (Reset) orphans <= '0;
      else       orphans <= orphan_next;
   end

   // Frame size is captured once per search
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_w <= '0;
         frame_h <= '0;
      end else if (start_ok) begin
         frame_w <= FrameW;
         frame_h <= FrameH;
      end
   end

   // Strict less-than keeps the earliest raster position on ties
   always_ff @(posedge Clk) begin
      if (Reset || start_ok) begin
         BestSad <= SAD_MAX;
         BestX   <= '0;
         BestY   <= '0;
      end else if (real_ret && (SadIn < BestSad)) begin
         BestSad <= SadIn;
         BestX   <= res_x;
         BestY   <= res_y;
      end
   end

   // Sticky flag for results nobody asked for
   always_ff @(posedge Clk) begin
      if (Reset)         Error <= 1'b0;
      else if (stray)    Error <= 1'b1;
      else if (start_ok) Error <= 1'b0;
   end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - randomized self-checking bench for sad_search_ctrl
module tb_sad_search_ctrl;

   logic        Clk = 1'b0;
   logic        Reset, Start, Abort, WinReady, SadValid;
   logic [7:0]  FrameW, FrameH, WinX, WinY, BestX, BestY;
   logic [31:0] SadIn, BestSad;
   logic        WinValid, Busy, Done, Error;

   sad_search_ctrl #(.MAX_OUT(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
      .FrameW(FrameW), .FrameH(FrameH),
      .WinValid(WinValid), .WinReady(WinReady), .WinX(WinX), .WinY(WinY),
      .SadValid(SadValid), .SadIn(SadIn),
      .Busy(Busy), .Done(Done), .BestSad(BestSad), .BestX(BestX), .BestY(BestY),
      .Error(Error)
   );

   always #5 Clk = ~Clk;

   int total_cnt = 0;
   int bad_cnt = 0;

   int nx, ny, npos, cyc, issued, returned, done_cnt, done_cyc, last_ret_cyc, order_bad, unstable;
   logic [31:0] sads [256];
   int          pend_due [$];
   logic [31:0] pend_sad [$];
   logic        prev_stall;
   logic [7:0]  prev_x, prev_y;
   logic [31:0] exp_best;
   int          exp_bx, exp_by;

   // Reference: minimum over the first n results in raster order, earliest wins ties
   task automatic model_best(input int n);
      exp_best = 32'hFFFF_FFFF;
      exp_bx = 0;
      exp_by = 0;
      for (int i = 0; i < n; i++) begin
         if (sads[i] < exp_best) begin
            exp_best = sads[i];
            exp_bx = i % nx;
            exp_by = i / nx;
         end
      end
   endtask

   task automatic start_search(input int fw, input int fh);
      nx = fw - 3;
      ny = fh - 3;
      npos = (nx > 0 && ny > 0) ? nx * ny : 0;
      issued = 0; returned = 0; done_cnt = 0; done_cyc = -1; last_ret_cyc = -1;
      order_bad = 0; unstable = 0; prev_stall = 1'b0;
      pend_due.delete();
      pend_sad.delete();
      @(negedge Clk);
      Start = 1'b1; FrameW = 8'(fw); FrameH = 8'(fh); WinReady = 1'b0; SadValid = 1'b0;
      cyc = 0;
      @(posedge Clk); #1;
      Start = 1'b0;
      cyc = 1;
   endtask

   // One cycle of datapath behaviour: random ready, fixed-latency in-order results
   task automatic step(input int ready_pct, input bit allow_ret, input int lat);
      @(negedge Clk);
      if (Done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (prev_stall && (WinX !== prev_x || WinY !== prev_y)) unstable++;
      WinReady = ($urandom_range(0, 99) < ready_pct);
      SadValid = 1'b0;
      if (allow_ret && pend_due.size() > 0 && pend_due[0] <= cyc) begin
         SadValid = 1'b1;
         SadIn = pend_sad.pop_front();
         void'(pend_due.pop_front());
         returned++;
         last_ret_cyc = cyc;
      end
      if (WinValid === 1'b1 && WinReady) begin
         if (issued >= npos || WinX !== 8'(issued % nx) || WinY !== 8'(issued / nx)) order_bad++;
         pend_due.push_back(cyc + lat);
         pend_sad.push_back(sads[issued % 256]);
         issued++;
      end
      prev_stall = (WinValid === 1'b1) && !WinReady;
      prev_x = WinX;
      prev_y = WinY;
      cyc++;
      @(posedge Clk); #1;
   endtask

   task automatic run_to_done(input int ready_pct, input int lat, input int limit);
      int n = 0;
      while (done_cnt == 0 && n < limit) begin
         step(ready_pct, 1'b1, lat);
         n++;
      end
      repeat (3) step(ready_pct, 1'b1, lat);
      total_cnt++;
      if (done_cnt == 0) begin
         bad_cnt++;
         $display("FAIL done_timeout: no Done after %0d cycles, want a pulse", limit);
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1; Start = 1'b0; Abort = 1'b0; WinReady = 1'b0; SadValid = 1'b0;
      SadIn = '0; FrameW = '0; FrameH = '0;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      total_cnt++;
      if ({WinValid, Busy, Done, Error} !== 4'b0000) begin
         bad_cnt++;
         $display("FAIL reset_flags: got %b want 0000", {WinValid, Busy, Done, Error});
      end
      total_cnt++;
      if ({WinX, WinY, BestX, BestY, BestSad} !== {32'h0, 32'hFFFF_FFFF}) begin
         bad_cnt++;
         $display("FAIL reset_values: got %h want %h", {WinX, WinY, BestX, BestY, BestSad}, {32'h0, 32'hFFFF_FFFF});
      end
   endtask

   task automatic test_small_frame;
      sads[0] = 10; sads[1] = 7; sads[2] = 7; sads[3] = 9;
      start_search(5, 5);
      run_to_done(100, 3, 100);
      total_cnt++;
      if (issued != 4 || order_bad != 0) begin
         bad_cnt++;
         $display("FAIL small_issue: got issued=%0d order_bad=%0d want 4/0", issued, order_bad);
      end
      total_cnt++;
      if ({BestSad, BestX, BestY} !== {32'd7, 8'd1, 8'd0}) begin
         bad_cnt++;
         $display("FAIL small_best: got %0d@(%0d,%0d) want 7@(1,0)", BestSad, BestX, BestY);
      end
      total_cnt++;
      if (done_cnt != 1 || done_cyc != last_ret_cyc + 1) begin
         bad_cnt++;
         $display("FAIL small_done: got pulses=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_ret_cyc + 1);
      end
      total_cnt++;
      if (Error !== 1'b0) begin
         bad_cnt++;
         $display("FAIL small_error: got %b want 0", Error);
      end
   endtask

   task automatic test_empty_frame;
      start_search(3, 8);
      repeat (5) step(100, 1'b1, 1);
      total_cnt++;
      if (issued != 0) begin
         bad_cnt++;
         $display("FAIL empty_issue: got %0d accepts want 0", issued);
      end
      total_cnt++;
      if (done_cnt != 1 || done_cyc < 1 || done_cyc > 2) begin
         bad_cnt++;
         $display("FAIL empty_done: got pulses=%0d at cycle %0d want 1 within 2 cycles", done_cnt, done_cyc);
      end
      total_cnt++;
      if ({BestSad, BestX, BestY, Busy} !== {32'hFFFF_FFFF, 8'd0, 8'd0, 1'b0}) begin
         bad_cnt++;
         $display("FAIL empty_best: got %h,%0d,%0d busy=%b want ffffffff,0,0 busy=0", BestSad, BestX, BestY, Busy);
      end
   endtask

   task automatic test_window_limit;
      for (int i = 0; i < 81; i++) sads[i] = $urandom_range(0, 1000);
      start_search(12, 12);
      repeat (20) step(100, 1'b0, 2);
      total_cnt++;
      if (issued != 8 || WinValid !== 1'b0) begin
         bad_cnt++;
         $display("FAIL limit_full: got accepts=%0d valid=%b want 8/0", issued, WinValid);
      end
      step(100, 1'b1, 2);
      repeat (4) step(100, 1'b0, 2);
      total_cnt++;
      if (issued != 9) begin
         bad_cnt++;
         $display("FAIL limit_one_more: got accepts=%0d want 9", issued);
      end
      run_to_done(100, 2, 2000);
      model_best(81);
      total_cnt++;
      if (issued != 81 || returned != 81 || order_bad != 0) begin
         bad_cnt++;
         $display("FAIL limit_all: got issued=%0d returned=%0d order_bad=%0d want 81/81/0", issued, returned, order_bad);
      end
      total_cnt++;
      if ({BestSad, BestX, BestY} !== {exp_best, 8'(exp_bx), 8'(exp_by)}) begin
         bad_cnt++;
         $display("FAIL limit_best: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", BestSad, BestX, BestY, exp_best, exp_bx, exp_by);
      end
   endtask

   task automatic test_random_stall;
      for (int r = 0; r < 3; r++) begin
         int fw = 5 + $urandom_range(0, 5);
         int fh = 4 + $urandom_range(0, 5);
         for (int i = 0; i < 256; i++) sads[i] = $urandom_range(0, 40);
         start_search(fw, fh);
         run_to_done(60, 1 + 2 * r, 3000);
         model_best(npos);
         total_cnt++;
         if (issued != npos || order_bad != 0 || unstable != 0) begin
            bad_cnt++;
            $display("FAIL stall_order run%0d: got issued=%0d order_bad=%0d unstable=%0d want %0d/0/0", r, issued, order_bad, unstable, npos);
         end
         total_cnt++;
         if ({BestSad, BestX, BestY} !== {exp_best, 8'(exp_bx), 8'(exp_by)}) begin
            bad_cnt++;
            $display("FAIL stall_best run%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", r, BestSad, BestX, BestY, exp_best, exp_bx, exp_by);
         end
         total_cnt++;
         if (done_cnt != 1 || done_cyc != last_ret_cyc + 1 || Error !== 1'b0) begin
            bad_cnt++;
            $display("FAIL stall_done run%0d: got pulses=%0d at %0d err=%b want 1 at %0d err=0", r, done_cnt, done_cyc, Error, last_ret_cyc + 1);
         end
      end
   endtask

   task automatic test_abort;
      int n = 0;
      for (int i = 0; i < 16; i++) sads[i] = $urandom_range(0, 100);
      start_search(7, 7);
      while (issued < 5 && n < 50) begin
         step(100, 1'b1, 3);
         n++;
      end
      total_cnt++;
      if (issued != 5 || returned != 2) begin
         bad_cnt++;
         $display("FAIL abort_setup: got issued=%0d returned=%0d want 5/2", issued, returned);
      end
      @(negedge Clk);
      Abort = 1'b1; WinReady = 1'b0; SadValid = 1'b0;
      @(posedge Clk); #1;
      Abort = 1'b0;
      total_cnt++;
      if ({Busy, WinValid, Done} !== 3'b000) begin
         bad_cnt++;
         $display("FAIL abort_idle: got busy/valid/done=%b want 000", {Busy, WinValid, Done});
      end
      repeat (8) step(0, 1'b1, 3);
      model_best(2);
      total_cnt++;
      if (returned != 5 || done_cnt != 0 || Error !== 1'b0) begin
         bad_cnt++;
         $display("FAIL abort_late: got returned=%0d done=%0d err=%b want 5/0/0", returned, done_cnt, Error);
      end
      total_cnt++;
      if ({BestSad, BestX, BestY} !== {exp_best, 8'(exp_bx), 8'(exp_by)}) begin
         bad_cnt++;
         $display("FAIL abort_partial: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", BestSad, BestX, BestY, exp_best, exp_bx, exp_by);
      end
      for (int i = 0; i < 4; i++) sads[i] = $urandom_range(0, 100);
      start_search(5, 5);
      run_to_done(100, 2, 100);
      model_best(4);
      total_cnt++;
      if (issued != 4 || order_bad != 0 || done_cnt != 1 || Error !== 1'b0 ||
          {BestSad, BestX, BestY} !== {exp_best, 8'(exp_bx), 8'(exp_by)}) begin
         bad_cnt++;
         $display("FAIL abort_restart: got issued=%0d bad=%0d done=%0d err=%b best=%0d@(%0d,%0d) want 4/0/1/0 %0d@(%0d,%0d)",
                  issued, order_bad, done_cnt, Error, BestSad, BestX, BestY, exp_best, exp_bx, exp_by);
      end
   endtask

   task automatic test_error;
      @(negedge Clk);
      SadValid = 1'b1; SadIn = 32'd0; WinReady = 1'b0;
      @(posedge Clk); #1;
      SadValid = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      total_cnt++;
      if (Error !== 1'b1 || BestSad !== exp_best) begin
         bad_cnt++;
         $display("FAIL error_set: got err=%b best=%0d want 1 and %0d", Error, BestSad, exp_best);
      end
      start_search(5, 5);
      total_cnt++;
      if (Error !== 1'b0) begin
         bad_cnt++;
         $display("FAIL error_clear: got %b want 0", Error);
      end
      run_to_done(100, 1, 100);
   endtask

   task automatic test_reset_in_drain;
      int n = 0;
      for (int i = 0; i < 9; i++) sads[i] = $urandom_range(0, 100);
      start_search(6, 6);
      while (issued < 9 && n < 50) begin
         step(100, 1'b1, 3);
         n++;
      end
      model_best(returned);
      total_cnt++;
      if (Busy !== 1'b1 || WinValid !== 1'b0 || BestSad !== exp_best) begin
         bad_cnt++;
         $display("FAIL drain_state: got busy=%b valid=%b best=%0d want 1/0/%0d", Busy, WinValid, BestSad, exp_best);
      end
      @(negedge Clk);
      Reset = 1'b1; WinReady = 1'b0; SadValid = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      pend_due.delete();
      pend_sad.delete();
      total_cnt++;
      if ({WinValid, Busy, Done, Error, WinX, WinY, BestX, BestY, BestSad} !== {4'b0, 32'h0, 32'hFFFF_FFFF}) begin
         bad_cnt++;
         $display("FAIL drain_reset: got %h want %h", {WinValid, Busy, Done, Error, WinX, WinY, BestX, BestY, BestSad},
                  {4'b0, 32'h0, 32'hFFFF_FFFF});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_small_frame();
      test_empty_frame();
      test_window_limit();
      test_random_stall();
      test_abort();
      test_error();
      test_reset_in_drain();
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
